// File: rtl/key_debounce.sv
`timescale 1ns/1ps
// key_debounce
//
// Conditions the emulator's raw, bouncing, active-low push-button lines
// before they reach the KEY port of the design under emulation. Each line is
// synchronised into CLK by two flops, debounced by its own stability counter,
// and presented as a clean active-low level. One-cycle PRESS/RELEASE pulses
// are issued on the same edge that changes the debounced level.
//
// Compile-time option:
//   KEY_DEBOUNCE_AUTOREPEAT_EN  when defined, a key that stays down produces
//                               extra PRESS pulses REPEAT_DELAY cycles after
//                               the initial press and every REPEAT_PERIOD
//                               cycles after that. When undefined, no repeat
//                               logic exists and REPEAT_* are ignored.
//
// Parameters:
//   WIDTH            number of key lines
//   DEBOUNCE_CYCLES  synchronised cycles a new level must hold (>= 1)
//   REPEAT_DELAY     press-to-first-repeat distance in cycles (>= 1)
//   REPEAT_PERIOD    distance between repeat pulses in cycles (>= 1)
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   asynchronous reset, active-high
//   KEY_RAW  in   [WIDTH] raw key lines, 0 = pressed, asynchronous
//   KEY_OUT  out  [WIDTH] debounced key level, 0 = pressed
//   PRESS    out  [WIDTH] one-cycle pulse on debounced 1->0 (plus repeats)
//   RELEASE  out  [WIDTH] one-cycle pulse on debounced 0->1

module key_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] KEY_RAW,
  output logic [WIDTH-1:0] KEY_OUT,
  output logic [WIDTH-1:0] PRESS,
  output logic [WIDTH-1:0] RELEASE
);

  // Counter just wide enough to hold DEBOUNCE_CYCLES-1; a 1-cycle debounce
  // still gets a 1-bit counter that simply never leaves zero.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYCLES must be at least 1");
  end
  if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_repeat
    $error("key_debounce: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  logic [WIDTH-1:0] s1_p0;
  logic [WIDTH-1:0] s2_p1;
  logic [CNT_W-1:0] cnt_p2 [WIDTH];
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rpt_fire;

  // ---- stage p0/p1: two-flop synchroniser, idles at "released" ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_p0 <= '1;
      s2_p1 <= '1;
    end else begin
      s1_p0 <= KEY_RAW;
      s2_p1 <= s1_p0;
    end
  end

  // ---- stage p2: per-key stability counters ----
  // A key is accepted on the edge where its synchronised level has differed
  // from the debounced level for DEBOUNCE_CYCLES consecutive evaluations.
  always_comb begin
    differ = '0;
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      differ[i] = (s2_p1[i] != KEY_OUT[i]);
      accept[i] = differ[i] && (cnt_p2[i] == CNT_LAST);
    end
  end

  // Any cycle back at the accepted level restarts the count, which is what
  // rejects bounces shorter than the debounce window.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < WIDTH; i++) cnt_p2[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!differ[i] || accept[i]) cnt_p2[i] <= '0;
        else                         cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
      end
    end
  end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_p2 [WIDTH];
  logic [WIDTH-1:0] rpt_periodic_p2;
  logic [WIDTH-1:0] held;

  // A key counts as held only while debounced-down and not being released on
  // this edge, so a release edge can never carry a repeat pulse. The first
  // target is REPEAT_DELAY, every later one REPEAT_PERIOD.
  always_comb begin
    held     = '0;
    rpt_fire = '0;
    for (int i = 0; i < WIDTH; i++) begin
      held[i]     = !KEY_OUT[i] && !accept[i];
      rpt_fire[i] = held[i] &&
                    (rpt_cnt_p2[i] == (rpt_periodic_p2[i] ? PERIOD_LAST : DELAY_LAST));
    end
  end

  // The counter sits at zero whenever the key is up, which also covers the
  // press edge itself: counting starts on the edge after the press pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < WIDTH; i++) rpt_cnt_p2[i] <= '0;
      rpt_periodic_p2 <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!held[i]) begin
          rpt_cnt_p2[i]      <= '0;
          rpt_periodic_p2[i] <= 1'b0;
        end else if (rpt_fire[i]) begin
          rpt_cnt_p2[i]      <= '0;
          rpt_periodic_p2[i] <= 1'b1;
        end else begin
          rpt_cnt_p2[i]      <= rpt_cnt_p2[i] + RPT_W'(1);
        end
      end
    end
  end
`else
  assign rpt_fire = '0;
`endif

  // ---- stage p3: debounced level and edge pulses ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      KEY_OUT <= '1;
      PRESS   <= '0;
      RELEASE <= '0;
    end else begin
      KEY_OUT <= (KEY_OUT & ~accept) | (s2_p1 & accept);
      PRESS   <= (accept & ~s2_p1) | rpt_fire;
      RELEASE <= accept & s2_p1;
    end
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Input conditioner between the emulator's raw push-button inputs and the DUT's `KEY` port. Each of the active-low key lines is synchronised into `CLK`, debounced by a per-key stability counter, and presented as a clean active-low level. The block also produces one-cycle press and release pulses for downstream logic. An optional auto-repeat feature is selected at compile time.

## Interface
- `WIDTH`, default 4: number of key lines.
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a new synchronised level must hold before it is accepted. Legal minimum is 1.
- `REPEAT_DELAY`, default 64: cycles from a press pulse to the first repeat pulse. Used only with auto-repeat. Legal minimum is 1.
- `REPEAT_PERIOD`, default 16: cycles between successive repeat pulses. Used only with auto-repeat. Legal minimum is 1.
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RST`  in  1  asynchronous reset, active-high.
- `KEY_RAW`  in  WIDTH  raw key lines; asynchronous, may bounce; 0 = pressed.
- `KEY_OUT`  out  WIDTH  debounced key level; 0 = pressed; drives DUT `KEY`.
- `PRESS`  out  WIDTH  one-cycle pulse per key on a debounced 1→0 transition, plus repeat pulses when auto-repeat is enabled.
- `RELEASE`  out  WIDTH  one-cycle pulse per key on a debounced 0→1 transition.

## Operation
- **Synchroniser:** each key passes through a 2-flop synchroniser, giving `s1` then `s2`. Both flops reset to 1 (released).
- **Debounce counter:** each key has its own counter `cnt`, sized to hold `DEBOUNCE_CYCLES-1`. On each edge:
  - If `s2 == KEY_OUT[i]`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `KEY_OUT[i] <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- **Glitch rejection:** any single cycle in which `s2` returns to the accepted level restarts the count from 0.
- **Pulses:** `PRESS[i]` and `RELEASE[i]` are registered and asserted on the same edge that updates `KEY_OUT[i]`. They are high for exactly one cycle.
- **Key independence:** keys are fully independent. Simultaneous transitions on several keys produce simultaneous pulses.
- **Reset:** `RST` high clears all counters and forces `s1`, `s2` and `KEY_OUT` to all-ones and `PRESS`/`RELEASE` to 0. Reset takes effect immediately, including in the middle of a debounce, and any partial count is discarded.
  - A key held low across reset deassertion is debounced afresh and yields a normal `PRESS`.

## Timing
- `KEY_RAW[i]` changes before edge 0 and stays stable:
  - `s2` shows the new level after edge 1.
  - `KEY_OUT[i]` and the corresponding pulse appear after edge `DEBOUNCE_CYCLES+1`.
  - Total latency is `DEBOUNCE_CYCLES+2` cycles from the raw change, with one cycle of uncertainty from asynchronous sampling.
- **Minimum accepted pulse width:** a raw level must hold `DEBOUNCE_CYCLES` consecutive synchronised cycles to be accepted. Anything shorter produces no output change.
- **Output reset values:** `KEY_OUT` = all-ones, `PRESS` = 0, `RELEASE` = 0.
- **Pulse spacing:** `PRESS` and `RELEASE` for the same key are never high in the same cycle, and are separated by at least `DEBOUNCE_CYCLES` cycles.

## Configuration
- Macro `KEY_DEBOUNCE_AUTOREPEAT_EN`.
- **Defined:** each key has a repeat counter, cleared on the edge that issues the debounced `PRESS`.
  - While `KEY_OUT[i]==0`, an extra one-cycle `PRESS[i]` is issued `REPEAT_DELAY` cycles after the initial press.
  - Further pulses follow every `REPEAT_PERIOD` cycles.
  - A debounced release clears the repeat counter on the same edge as `RELEASE`, and no repeat pulse is issued on or after that edge.
  - `RST` clears the repeat counters.
- **Undefined:** no repeat logic is generated, the `REPEAT_*` parameters are ignored, and exactly one `PRESS` is issued per debounced press.

## Test plan
All scenarios use `WIDTH=4` and `DEBOUNCE_CYCLES=4`.
- **Clean press:** `KEY_RAW` 1111→1110 before edge 0 and held → `KEY_OUT`=1110 after edge 5; `PRESS`=0001 for exactly that cycle; `RELEASE`=0.
- **Bounce rejection:** `KEY_RAW[1]` toggles low for 3 cycles, high for 1, low for 3, then high → `KEY_OUT` stays 1111; no pulses.
- **Simultaneous keys:** `KEY_RAW` 1111→0101, held for 20 cycles, then →1111 → `PRESS`=1010 in one cycle after edge 5; 20 cycles later `RELEASE`=1010 in one cycle; `KEY_OUT` returns to 1111.
- **Reset mid-debounce:** `KEY_RAW[2]` low, `RST` pulsed at edge 3 → `KEY_OUT`=1111 immediately; after deassertion the full 6-cycle latency restarts and one `PRESS`=0100 is issued.
- **Auto-repeat** (macro defined, `REPEAT_DELAY=10`, `REPEAT_PERIOD=5`): hold key 0 for 30 cycles after the initial `PRESS` → pulses at +0, +10, +15, +20, +25; release → `RELEASE`=0001 and no further `PRESS`.
- **Same stimulus, macro undefined:** exactly one `PRESS` pulse.
